con_port_ctrl: RTL

- Parametrised controller for the shared accelerator connection bus (NB_CONS lanes of DATA_WIDTH) between the host/testbench and the convolution core.
- Input phase: host beats pass to the core's input stream.
- Output phase: after a turnaround gap the controller takes bus ownership (driving_cons), streams result beats and tags each beat with output_x/output_y/output_ch. When the feature map is complete it hands the bus back to the host.
- Sits at the top_system boundary and replaces fixed three-lane bus handling.

---
 rtl/con_port_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/con_port_ctrl.sv
// Connection-bus port controller between the host and the convolution core.
// The host owns the bus during the input phase. During the output phase the
// controller owns the bus and streams result beats tagged with their
// (x, y, ch) position. Every change of bus direction is separated by a
// turnaround gap of TURNAROUND idle cycles.
module con_port_ctrl #(
    parameter int DATA_WIDTH         = 16,
    parameter int NB_CONS            = 3,
    parameter int FEATURE_MAP_WIDTH  = 64,
    parameter int FEATURE_MAP_HEIGHT = 64,
    parameter int OUTPUT_NB_CHANNELS = 32,
    parameter int TURNAROUND         = 1,
    parameter bit CH_MAJOR           = 1'b0
) (
    input  logic                               clk,
    input  logic                               arst_in,
    input  logic [NB_CONS*DATA_WIDTH-1:0]      con_in,
    input  logic                               con_valid_in,
    output logic                               con_ready_out,
    output logic [NB_CONS*DATA_WIDTH-1:0]      con_out,
    output logic                               con_valid_out,
    input  logic                               con_ready_in,
    output logic                               driving_cons,
    output logic [NB_CONS*DATA_WIDTH-1:0]      in_data,
    output logic                               in_valid,
    input  logic                               in_ready,
    input  logic [NB_CONS*DATA_WIDTH-1:0]      res_data,
    input  logic                               res_valid,
    output logic                               res_ready,
    input  logic                               out_mode_req,
    output logic                               output_valid,
    output logic [((FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1)-1:0] output_x,
    output logic [((FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1)-1:0] output_y,
    output logic [((OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1)-1:0] output_ch,
    output logic                               frame_done
);

    localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
    localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
    localparam int CW  = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
    localparam int TAW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    localparam logic [XW-1:0]  X_LAST  = XW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [CW-1:0]  CH_LAST = CW'(OUTPUT_NB_CHANNELS - NB_CONS);
    localparam logic [CW-1:0]  CH_STEP = CW'(NB_CONS);
    localparam logic [TAW-1:0] TA_LAST = TAW'(TURNAROUND - 1);

    localparam logic [1:0] S_IN     = 2'd0;
    localparam logic [1:0] S_TA_OUT = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;
    localparam logic [1:0] S_TA_IN  = 2'd3;

    // Each output beat carries NB_CONS whole channels, so the channel count
    // has to split evenly into beats.
    if (OUTPUT_NB_CHANNELS % NB_CONS != 0) begin : g_bad_channels
        $error("OUTPUT_NB_CHANNELS must be a multiple of NB_CONS");
    end
    if (TURNAROUND < 1) begin : g_bad_turnaround
        $error("TURNAROUND must be at least 1");
    end

    logic [1:0]     state;
    logic [TAW-1:0] ta_cnt;
    logic [XW-1:0]  x_cnt;
    logic [YW-1:0]  y_cnt;
    logic [CW-1:0]  ch_cnt;
    logic           at_last;
    logic           out_hs;
    logic           last_hs;
    logic           res_hs;
    logic           ta_done;

    // Handshake decode and bus-side outputs; pure combinational decode of state.
    always_comb begin
        at_last       = (x_cnt == X_LAST) && (y_cnt == Y_LAST) && (ch_cnt == CH_LAST);
        out_hs        = con_valid_out & con_ready_in;
        last_hs       = out_hs & at_last;
        // Once the frame's final beat sits in the output register no further
        // core beat belongs to this frame, so nothing more is accepted.
        res_ready     = (state == S_OUT) & (~con_valid_out | con_ready_in)
                        & ~(con_valid_out & at_last);
        res_hs        = res_valid & res_ready;
        ta_done       = (ta_cnt == TA_LAST);
        in_data       = con_in;
        in_valid      = (state == S_IN) & con_valid_in;
        con_ready_out = (state == S_IN) & in_ready;
        driving_cons  = (state == S_OUT);
        output_valid  = con_valid_out;
        output_x      = x_cnt;
        output_y      = y_cnt;
        output_ch     = ch_cnt;
    end

    // Phase sequencer: IN -> TA_OUT -> OUT -> TA_IN -> IN, with the turnaround
    // counter timing both gap states.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state  <= S_IN;
            ta_cnt <= '0;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments
            // only, so every flop samples pre-edge values regardless of order.
            ta_cnt <= '0;
            case (state)
                S_IN: begin
                    if (out_mode_req) state <= S_TA_OUT;
                end
                S_TA_OUT: begin
                    if (ta_done) state <= S_OUT;
                    else         ta_cnt <= ta_cnt + TAW'(1);
                end
                S_OUT: begin
                    if (last_hs) state <= S_TA_IN;
                end
                default: begin
                    if (ta_done) state <= S_IN;
                    else         ta_cnt <= ta_cnt + TAW'(1);
                end
            endcase
        end
    end

    // One-deep output register: load on a core handshake, empty on a bus
    // handshake, and flag the cycle after the frame's last beat leaves.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            con_out       <= '0;
            con_valid_out <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= last_hs;
            if (last_hs) begin
                con_valid_out <= 1'b0;
            end else if (res_hs) begin
                con_out       <= res_data;
                con_valid_out <= 1'b1;
            end else if (out_hs) begin
                con_valid_out <= 1'b0;
            end
        end
    end

    // Position counters: they always hold the tag of the beat currently in
    // the output register and step only when that beat is accepted.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            ch_cnt <= '0;
        end else if (last_hs) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            ch_cnt <= '0;
        end else if (out_hs) begin
            if (!CH_MAJOR) begin
                if (ch_cnt == CH_LAST) begin
                    ch_cnt <= '0;
                    if (x_cnt == X_LAST) begin
                        x_cnt <= '0;
                        y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + YW'(1);
                    end else begin
                        x_cnt <= x_cnt + XW'(1);
                    end
                end else begin
                    ch_cnt <= ch_cnt + CH_STEP;
                end
            end else begin
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    if (y_cnt == Y_LAST) begin
                        y_cnt  <= '0;
                        ch_cnt <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + CH_STEP;
                    end else begin
                        y_cnt <= y_cnt + YW'(1);
                    end
                end else begin
                    x_cnt <= x_cnt + XW'(1);
                end
            end
        end
    end

endmodule
